// File: rtl/fetch.sv
// Instruction fetch stage: holds the PC, issues in-order word reads and
// buffers the returned words for decode behind a valid/ready handshake.
module fetch #(
   parameter int unsigned         INSTR_WIDTH = 32,
   parameter int unsigned         PC_WIDTH    = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter int unsigned         BUF_DEPTH   = 2
) (
   input  logic                   clk,
   input  logic                   rstn,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [PC_WIDTH-1:0]    imem_req_addr,
   input  logic                   imem_resp_valid,
   input  logic [INSTR_WIDTH-1:0] imem_resp_data,
   input  logic                   redirect_valid,
   input  logic [PC_WIDTH-1:0]    redirect_pc,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_WIDTH-1:0] instr_out,
   output logic [PC_WIDTH-1:0]    pc_out
);

   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [INSTR_WIDTH-1:0] NOP      = INSTR_WIDTH'(32'h0000_0013);
   localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(BUF_DEPTH - 1);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t                 state_q, state_d;
   logic                   live_q;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [CNT_W-1:0]       outst_q, outst_d;
   logic [CNT_W-1:0]       disc_q, disc_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [PTR_W-1:0]       rd_q, rd_d, wr_q, wr_d;
   logic [INSTR_WIDTH-1:0] buf_instr [BUF_DEPTH];
   logic [PC_WIDTH-1:0]    buf_pc    [BUF_DEPTH];
   logic                   valid_q, valid_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;

   logic                   accept, pop, push, credit_ok;
   logic [SUM_W-1:0]       used, disc_sum;
   logic [PC_WIDTH-1:0]    resp_pc;
   logic [INSTR_WIDTH-1:0] head_instr;
   logic [PC_WIDTH-1:0]    head_pc;
   logic                   unused_rpc_lsb;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Low redirect bits are ignored; the target is always word aligned.
   assign unused_rpc_lsb = ^redirect_pc[1:0];

   assign imem_req_addr = pc_q;
   assign instr_valid   = valid_q;
   assign instr_out     = instr_q;
   assign pc_out        = pc_out_q;

   // Requests are sequential since the last redirect, so the oldest
   // outstanding request sits 'outstanding' words behind pc.
   assign resp_pc = pc_q - (PC_WIDTH'(outst_q) << 2);

   // Request credit; a buffer slot freed by this cycle's pop counts as free.
   always_comb begin
      pop            = valid_q && instr_ready;
      used           = SUM_W'(outst_q) + SUM_W'(cnt_q) - SUM_W'(pop);
      credit_ok      = used < SUM_W'(BUF_DEPTH);
      imem_req_valid = live_q && (state_q == RUN) && !redirect_valid && credit_ok;
      accept         = imem_req_valid && imem_req_ready;
   end

   // Next-state for PC, counters, buffer pointers and presented outputs.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      outst_d  = outst_q;
      disc_d   = disc_q;
      cnt_d    = cnt_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      push     = 1'b0;
      disc_sum = '0;

      if (redirect_valid) begin
         pc_d     = {redirect_pc[PC_WIDTH-1:2], 2'b00};
         disc_sum = SUM_W'(outst_q) + ((state_q == FLUSH) ? SUM_W'(disc_q) : '0)
                    - SUM_W'(imem_resp_valid);
         disc_d   = CNT_W'(disc_sum);
         outst_d  = '0;
         cnt_d    = '0;
         rd_d     = '0;
         wr_d     = '0;
         state_d  = (disc_d == '0) ? RUN : FLUSH;
      end else if (state_q == FLUSH) begin
         if (imem_resp_valid) begin
            disc_d = disc_q - CNT_W'(1);
            if (disc_q == CNT_W'(1)) state_d = RUN;
         end
      end else begin
         push    = imem_resp_valid;
         if (accept) pc_d = pc_q + PC_WIDTH'(4);
         outst_d = outst_q + CNT_W'(accept) - CNT_W'(imem_resp_valid);
         cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);
         if (pop)  rd_d = ptr_inc(rd_q);
         if (push) wr_d = ptr_inc(wr_q);
      end

      // The new head is the incoming word when it lands in the head slot.
      if (push && (rd_d == wr_q)) begin
         head_instr = imem_resp_data;
         head_pc    = resp_pc;
      end else begin
         head_instr = buf_instr[rd_d];
         head_pc    = buf_pc[rd_d];
      end

      valid_d  = (state_d == RUN) && (cnt_d != '0);
      instr_d  = valid_d ? head_instr : NOP;
      pc_out_d = valid_d ? head_pc : pc_out_q;
   end

   // Buffer storage; contents are qualified by the occupancy count.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr[wr_q] <= imem_resp_data;
         buf_pc[wr_q]    <= resp_pc;
      end
   end

   // State register, counters and registered decode-side outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= RUN;
         live_q   <= 1'b0;
         pc_q     <= RESET_PC;
         outst_q  <= '0;
         disc_q   <= '0;
         cnt_q    <= '0;
         rd_q     <= '0;
         wr_q     <= '0;
         valid_q  <= 1'b0;
         instr_q  <= NOP;
         pc_out_q <= RESET_PC;
      end else begin
         state_q  <= state_d;
         live_q   <= 1'b1;
         pc_q     <= pc_d;
         outst_q  <= outst_d;
         disc_q   <= disc_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
      end
   end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: memory model plus a queue-based reference of the fetch
// stage, directed scenarios followed by a randomized run.
module tb_fetch;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid, instr_ready;
   logic [31:0] instr_out, pc_out;

   logic        w_req_valid, w_instr_valid;
   logic [31:0] w_req_addr, w_instr_out, w_pc_out;

   fetch #(.INSTR_WIDTH(32), .PC_WIDTH(32), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) u_dut (
      .clk(clk), .rstn(rstn),
      .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
      .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_out(instr_out), .pc_out(pc_out)
   );

   fetch #(.INSTR_WIDTH(32), .PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(DEPTH)) u_wrap (
      .clk(clk), .rstn(rstn),
      .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
      .imem_resp_valid(1'b0), .imem_resp_data(32'h0),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .instr_valid(w_instr_valid), .instr_ready(1'b1),
      .instr_out(w_instr_out), .pc_out(w_pc_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   int checks = 0;
   int errors = 0;

   // Reference state
   entry_t      m_fifo[$];
   logic [31:0] m_addrq[$];
   int          m_disc;
   bit          m_flush, m_live;
   logic [31:0] m_pc, m_last_pc;

   // Memory model
   int          mem_due[$];
   logic [31:0] mem_data[$];
   int          last_due, cyc, lat_min, lat_max;
   logic [31:0] salt;
   int          n_acc;

   // Stimulus controls
   bit          s_rdr, s_ird, s_qrd;
   logic [31:0] s_rdr_pc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_fifo.delete();
      m_addrq.delete();
      m_disc    = 0;
      m_flush   = 0;
      m_live    = 0;
      m_pc      = 32'h0;
      m_last_pc = 32'h0;
      mem_due.delete();
      mem_data.delete();
      last_due  = -1;
      cyc       = 0;
   endtask

   // Asynchronous reset mid-cycle; outputs must clear immediately.
   task automatic do_reset();
      #2 rstn = 1'b0;
      resp_valid     = 1'b0;
      redirect_valid = 1'b0;
      #1;
      check("rst_req_valid", 32'(req_valid), 32'h0);
      check("rst_req_addr", req_addr, 32'h0);
      check("rst_instr_valid", 32'(instr_valid), 32'h0);
      check("rst_instr_out", instr_out, NOP);
      check("rst_pc_out", pc_out, 32'h0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // One clock cycle: drive, compare against the reference, advance both.
   task automatic step();
      bit          rv, e_pop, e_req, e_acc, vis;
      logic [31:0] rd, e_instr;
      int          used, due, d;
      entry_t      e;
      rv = 0;
      rd = '0;
      if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
         rv = 1;
         rd = mem_data[0];
         void'(mem_due.pop_front());
         void'(mem_data.pop_front());
      end
      resp_valid     = rv;
      resp_data      = rd;
      redirect_valid = s_rdr;
      redirect_pc    = s_rdr_pc;
      instr_ready    = s_ird;
      req_ready      = s_qrd;
      #1;
      vis     = (m_fifo.size() > 0) && !m_flush;
      e_instr = vis ? m_fifo[0].instr : NOP;
      e_pop   = vis && s_ird;
      used    = m_addrq.size() + m_fifo.size() - (e_pop ? 1 : 0);
      e_req   = m_live && !m_flush && !s_rdr && (used < DEPTH);
      e_acc   = e_req && s_qrd;
      check("req_valid", 32'(req_valid), 32'(e_req));
      check("req_addr", req_addr, m_pc);
      check("instr_valid", 32'(instr_valid), 32'(vis));
      check("instr_out", instr_out, e_instr);
      check("pc_out", pc_out, m_last_pc);
      if (req_valid && req_ready) n_acc++;
      if (e_acc) begin
         due = cyc + $urandom_range(lat_max, lat_min);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mem_due.push_back(due);
         mem_data.push_back(m_pc ^ salt);
      end
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      resp_valid     = 1'b0;
      if (s_rdr) begin
         d = m_addrq.size() - (rv ? 1 : 0) + (m_flush ? m_disc : 0);
         m_pc = {s_rdr_pc[31:2], 2'b00};
         m_fifo.delete();
         m_addrq.delete();
         m_disc  = d;
         m_flush = (d != 0);
      end else if (m_flush) begin
         if (rv) begin
            m_disc--;
            if (m_disc == 0) m_flush = 0;
         end
      end else begin
         if (e_pop) void'(m_fifo.pop_front());
         if (rv && m_addrq.size() > 0) begin
            e.instr = rd;
            e.pc    = m_addrq.pop_front();
            m_fifo.push_back(e);
         end
         if (e_acc) begin
            m_addrq.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
      m_live = 1;
      if (m_fifo.size() > 0 && !m_flush) m_last_pc = m_fifo[0].pc;
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      bit prev;
      resp_valid = 0; resp_data = '0; redirect_valid = 0; redirect_pc = '0;
      instr_ready = 1; req_ready = 1;
      salt = 32'h0; lat_min = 1; lat_max = 1;
      s_rdr = 0; s_rdr_pc = '0; s_ird = 1; s_qrd = 1;
      model_reset();

      // Streaming with 1-cycle memory returning the address; PC wrap on u_wrap.
      do_reset();
      check("wrap_rst_addr", w_req_addr, 32'hFFFF_FFFC);
      check("wrap_rst_valid", 32'(w_req_valid), 32'h0);
      step();
      check("wrap_first_valid", 32'(w_req_valid), 32'h1);
      check("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
      step();
      check("wrap_second_addr", w_req_addr, 32'h0);
      step();
      check("wrap_third_addr", w_req_addr, 32'h4);
      check("wrap_credit_stop", 32'(w_req_valid), 32'h0);
      check("stream_valid3", 32'(instr_valid), 32'h1);
      check("stream_pc0", pc_out, 32'h0);
      check("stream_data0", instr_out, 32'h0);
      step();
      check("stream_pc4", pc_out, 32'h4);
      step();
      check("stream_pc8", pc_out, 32'h8);
      check("stream_data8", instr_out, 32'h8);
      repeat (10) step();

      // Decode stalled: credits stop requests after the buffer budget.
      do_reset();
      salt = 32'h5A5A_0000;
      s_ird = 0;
      n_acc = 0;
      repeat (8) step();
      check("stall_accepts", 32'(n_acc), 32'd2);
      check("stall_req_valid", 32'(req_valid), 32'h0);
      s_ird = 1;
      repeat (12) step();

      // Redirect with two stale requests on 3-cycle memory.
      do_reset();
      lat_min = 3; lat_max = 3;
      repeat (3) step();
      s_rdr = 1; s_rdr_pc = 32'h0000_0101;
      step();
      s_rdr = 0;
      repeat (2) step();
      check("flush_exit_req", 32'(req_valid), 32'h1);
      check("flush_target_addr", req_addr, 32'h100);
      repeat (4) step();
      check("target_valid", 32'(instr_valid), 32'h1);
      check("target_pc", pc_out, 32'h100);
      repeat (8) step();

      // Redirect coinciding with the only outstanding response.
      do_reset();
      lat_min = 1; lat_max = 1;
      repeat (2) step();
      s_rdr = 1; s_rdr_pc = 32'h0000_0200;
      step();
      s_rdr = 0;
      check("noflush_req", 32'(req_valid), 32'h1);
      check("noflush_addr", req_addr, 32'h200);
      check("noflush_dropped", 32'(instr_valid), 32'h0);
      repeat (6) step();

      // Randomized traffic, latency and redirects.
      do_reset();
      salt = $urandom;
      lat_min = 1; lat_max = 4;
      prev = 0;
      for (int i = 0; i < 600; i++) begin
         s_ird    = ($urandom_range(3, 0) != 0);
         s_qrd    = ($urandom_range(3, 0) != 0);
         s_rdr    = !prev && ($urandom_range(15, 0) == 0);
         s_rdr_pc = $urandom;
         prev     = s_rdr;
         step();
      end
      s_rdr = 0; s_ird = 1; s_qrd = 1;
      repeat (10) step();

      // Reset while flushing with one stale response pending.
      do_reset();
      lat_min = 3; lat_max = 3;
      repeat (3) step();
      s_rdr = 1; s_rdr_pc = 32'h0000_0300;
      step();
      s_rdr = 0;
      step();
      do_reset();
      step();
      check("restart_req", 32'(req_valid), 32'h1);
      check("restart_addr", req_addr, 32'h0);
      repeat (8) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
